pipe_reg_elastic: RTL

//  Parametrised, stallable pipeline register for the ALU datapath. Replaces the

---
 rtl/pipe_reg_elastic.sv | 87 ++++++++
 1 files changed

// File: rtl/pipe_reg_elastic.sv
// pipe_reg_elastic: DEPTH-stage stallable pipeline register with one valid bit
// per stage. Bubbles collapse, downstream back-pressure propagates
// combinationally to in_ready, and flush synchronously kills every stage.
module pipe_reg_elastic #(
   parameter int unsigned       WIDTH      = 64,
   parameter int unsigned       DEPTH      = 2,
   parameter logic [WIDTH-1:0]  RESET_DATA = '0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [WIDTH-1:0]             in_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [WIDTH-1:0]             out_data,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

   localparam int unsigned OCC_W = $clog2(DEPTH + 1);

   logic [DEPTH-1:0] v_q, v_d;
   logic [WIDTH-1:0] d_q [DEPTH];
   logic [WIDTH-1:0] d_d [DEPTH];
   logic [DEPTH-1:0] adv;
   logic             acc_in;
   logic [OCC_W-1:0] occ_cnt;

   // Advance chain from the output stage back to stage 0. A scalar
   // accumulator carries the chain so no vector bit depends on another.
   always_comb begin : adv_chain
      logic chain;
      chain = out_ready;
      adv   = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         chain                = ~v_q[DEPTH-1-i] | chain;
         adv[DEPTH-1-i]       = chain;
      end
   end

   assign in_ready = adv[0] & ~flush;
   assign acc_in   = in_valid & in_ready;

   // Next-state: valid bits follow the advance chain; data loads only
   // when a valid item arrives so bubbles never toggle the data regs.
   always_comb begin
      v_d = v_q;
      d_d = d_q;
      if (flush) begin
         v_d = '0;
      end else begin
         if (adv[0]) begin
            v_d[0] = acc_in;
            if (acc_in) d_d[0] = in_data;
         end
         for (int unsigned k = 1; k < DEPTH; k++) begin
            if (adv[k]) begin
               v_d[k] = v_q[k-1];
               if (v_q[k-1]) d_d[k] = d_q[k-1];
            end
         end
      end
   end

   // Stage registers with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q <= '0;
         for (int unsigned k = 0; k < DEPTH; k++) d_q[k] <= RESET_DATA;
      end else begin
         v_q <= v_d;
         for (int unsigned k = 0; k < DEPTH; k++) d_q[k] <= d_d[k];
      end
   end

   // Occupancy is a popcount of the registered valid bits only.
   always_comb begin
      occ_cnt = '0;
      for (int unsigned k = 0; k < DEPTH; k++) occ_cnt = occ_cnt + OCC_W'(v_q[k]);
   end

   assign occupancy = occ_cnt;
   assign out_valid = v_q[DEPTH-1];
   assign out_data  = d_q[DEPTH-1];

endmodule
